serial_adder: RTL and testbench

Bit-serial adder that sits directly upstream of the single-bit full adder cell and drives it. It feeds one operand bit pair per clock, plus a registered carry, into one `Full_Adder` instance. It collects the sum bits into a result word. A start/busy/done handshake lets a controller request a WIDTH-bit addition and pick up the result, trading latency for a single adder cell.

---
 rtl/serial_adder_if.sv | 23 ++
 rtl/serial_adder.sv | 137 +++++++++++++
 tb/tb_serial_adder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle between a controller (master) and serial_adder (slave).
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one Full_Adder cell fed one operand bit pair per clock,
// with a registered carry; start/busy/done handshake over serial_adder_if.
module Full_Adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH:0]   psum_ext;

    Full_Adder u_fa (
        .A    (a_q[0]),
        .B    (b_q[0]),
        .Cin  (c_q),
        .S    (fa_s),
        .Cout (fa_cout)
    );

    // New sum bit enters at the MSB; the extended vector keeps the slice legal for WIDTH=1.
    assign psum_ext = {fa_s, psum_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = done_q;
        unique case (state_q)
            IDLE: begin
                done_d = 1'b0;
                busy_d = 1'b0;
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    c_d     = bus.cin;
                    cnt_d   = '0;
                    psum_d  = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                psum_d = psum_ext[WIDTH:1];
                c_d    = fa_cout;
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = psum_ext[WIDTH:1];
                    cout_d  = fa_cout;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 instance under randomized and directed traffic,
// plus WIDTH=1 and WIDTH=32 instances with directed and random sums.
module tb_serial_adder;
    localparam int unsigned W  = 8;
    localparam int          WI = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    serial_adder_if #(.WIDTH(8))  if8  ();
    serial_adder_if #(.WIDTH(1))  if1  ();
    serial_adder_if #(.WIDTH(32)) if32 ();

    serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_adder #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
    serial_adder #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

    typedef struct {
        logic [W:0] res;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         acc_last  = -100;
    int         next_free = 1 << 30;
    logic [W:0] held      = '0;

    // Reference: an accepted request at edge k yields a+b+cin, seen with done after edge k+W;
    // the adder accepts again no earlier than edge k+W+2.
    task automatic drive8(input logic st, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci);
        int   k;
        exp_t e;
        if8.start = st;
        if8.a     = a;
        if8.b     = b;
        if8.cin   = ci;
        k = cyc + 1;
        if (st && k >= next_free) begin
            e.res = (W+1)'(a) + (W+1)'(b) + (W+1)'(ci);
            e.cyc = k + WI;
            exp_q.push_back(e);
            acc_last  = k;
            next_free = k + WI + 2;
        end
        @(negedge clk);
    endtask

    task automatic idle8(input int n);
        for (int i = 0; i < n; i++)
            drive8(1'b0, W'($urandom), W'($urandom), 1'($urandom));
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", {63'd0, if8.busy}, 64'd0);
            chk("rst_done", {63'd0, if8.done}, 64'd0);
            chk("rst_result", {55'd0, if8.cout, if8.sum}, 64'd0);
        end else begin
            chk("busy", {63'd0, if8.busy},
                {63'd0, (cyc >= acc_last) && (cyc <= acc_last + WI - 1)});
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                mon_e = exp_q.pop_front();
                chk("done_missing_at", 64'(cyc), 64'(mon_e.cyc));
            end
            if (if8.done) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", {63'd0, if8.done}, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                    chk("result", {55'd0, if8.cout, if8.sum}, {55'd0, mon_e.res});
                    held = mon_e.res;
                end
            end else begin
                chk("hold", {55'd0, if8.cout, if8.sum}, {55'd0, held});
            end
        end
    end

    task automatic run1(input logic a, input logic b, input logic ci);
        int k;
        logic [1:0] exp;
        exp = 2'(a) + 2'(b) + 2'(ci);
        if1.start = 1'b1; if1.a = a; if1.b = b; if1.cin = ci;
        k = cyc + 1;
        @(negedge clk);
        if1.start = 1'b0; if1.a = 1'($urandom); if1.b = 1'($urandom);
        chk("w1_busy", {63'd0, if1.busy}, 64'd1);
        for (int i = 0; i < 8; i++) begin
            if (if1.done) break;
            @(negedge clk);
        end
        chk("w1_done_cycle", 64'(cyc), 64'(k + 1));
        chk("w1_result", {62'd0, if1.cout, if1.sum}, {62'd0, exp});
        @(negedge clk);
    endtask

    task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic ci);
        int k;
        logic [32:0] exp;
        exp = 33'(a) + 33'(b) + 33'(ci);
        if32.start = 1'b1; if32.a = a; if32.b = b; if32.cin = ci;
        k = cyc + 1;
        @(negedge clk);
        if32.start = 1'b0; if32.a = $urandom; if32.b = $urandom;
        chk("w32_busy", {63'd0, if32.busy}, 64'd1);
        for (int i = 0; i < 40; i++) begin
            if (if32.done) break;
            @(negedge clk);
        end
        chk("w32_done_cycle", 64'(cyc), 64'(k + 32));
        chk("w32_result", {31'd0, if32.cout, if32.sum}, {31'd0, exp});
        @(negedge clk);
    endtask

    initial begin
        if8.start  = 1'b0; if8.a  = '0; if8.b  = '0; if8.cin  = 1'b0;
        if1.start  = 1'b0; if1.a  = '0; if1.b  = '0; if1.cin  = 1'b0;
        if32.start = 1'b0; if32.a = '0; if32.b = '0; if32.cin = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_w1", {62'd0, if1.cout, if1.sum}, 64'd0);
        chk("reset_w32", {31'd0, if32.cout, if32.sum}, 64'd0);
        rst_n     = 1'b1;
        next_free = cyc + 1;
        idle8(2);

        drive8(1'b1, 8'h5A, 8'h3C, 1'b0);
        idle8(12);

        drive8(1'b1, 8'hFF, 8'h01, 1'b0);
        idle8(WI + 1);
        drive8(1'b1, 8'hFF, 8'hFF, 1'b1);
        idle8(WI + 2);

        // start during SHIFT and DONE must be ignored
        drive8(1'b1, 8'h5A, 8'h3C, 1'b0);
        for (int i = 0; i < WI + 1; i++) drive8(1'b1, 8'h11, 8'h22, 1'b0);
        idle8(WI + 4);

        drive8(1'b1, 8'h5A, 8'h3C, 1'b0);
        idle8(3);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        acc_last = -100;
        held     = '0;
        #1;
        chk("async_rst_busy", {63'd0, if8.busy}, 64'd0);
        chk("async_rst_done", {63'd0, if8.done}, 64'd0);
        chk("async_rst_result", {55'd0, if8.cout, if8.sum}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        next_free = cyc + 1;
        idle8(WI + 4);
        drive8(1'b1, 8'h01, 8'h02, 1'b0);
        idle8(WI + 3);

        for (int i = 0; i < 2000; i++)
            drive8($urandom_range(0, 3) == 0, W'($urandom), W'($urandom), 1'($urandom));
        idle8(WI + 3);

        for (int i = 0; i < 10100; i++)
            drive8(1'b1, W'($urandom), W'($urandom), 1'($urandom));
        idle8(WI + 4);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        run1(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) run1(1'($urandom), 1'($urandom), 1'($urandom));
        run32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        for (int i = 0; i < 6; i++) run32($urandom, $urandom, 1'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
